// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack arbiter: FSM state encoding,
// default geometry and the error-flag value reported on a rejected op.
package stack_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        POP_RD   = 3'd2,
        POP_WAIT = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 1024;

    // Value driven on req_err for push-while-full / pop-while-empty.
    localparam logic ERR = 1'b1;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [NREQ-1:0] hi_mask;
    logic [NREQ-1:0] req_hi;
    logic [NREQ-1:0] pick;

    genvar gi, gb;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign hi_mask[gi] = (IW'(gi) >= ptr);
        end
    endgenerate

    // Requests at or above the pointer win; otherwise wrap to the lowest one.
    assign req_hi    = req & hi_mask;
    assign pick      = (req_hi != '0) ? req_hi : req;
    assign grant     = pick & (~pick + 1'b1);
    assign grant_any = |req;

    generate
        for (gb = 0; gb < IW; gb++) begin : g_enc
            logic [NREQ-1:0] sel;
            for (gi = 0; gi < NREQ; gi++) begin : g_sel
                if (((gi >> gb) & 1) != 0) begin : g_on
                    assign sel[gi] = grant[gi];
                end else begin : g_off
                    assign sel[gi] = 1'b0;
                end
            end
            assign grant_idx[gb] = |sel;
        end
    endgenerate

endmodule

// File: rtl/stack_arbiter.sv
// Shares one synchronous-read stack RAM between NREQ requesters: round-robin
// grant, full/empty checking, stack pointer and RAM access sequencing.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_push,
    input  logic [NREQ*DW-1:0]      req_wdata,
    input  logic                    flush,
    output logic [NREQ-1:0]         req_ack,
    output logic                    req_err,
    output logic [DW-1:0]           req_rdata,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_re,
    input  logic [DW-1:0]           mem_rdata,
    output logic [AW-1:0]           stack_count,
    output logic                    stack_full,
    output logic                    stack_empty
);

    localparam int IW = $clog2(NREQ);

    state_t          state_reg;
    state_t          state_next;
    logic [AW-1:0]   count_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [IW-1:0]   id_reg;
    logic            flush_pend_reg;
    logic [NREQ-1:0] req_ack_reg;
    logic            req_err_reg;
    logic [DW-1:0]   req_rdata_reg;
    logic            mem_we_reg;
    logic            mem_re_reg;
    logic [AW-1:0]   mem_addr_reg;
    logic [DW-1:0]   mem_wdata_reg;

    logic [NREQ-1:0] win_grant;
    logic [IW-1:0]   win_idx;
    logic            win_any;
    logic [DW-1:0]   wdata_arr [NREQ];
    logic [DW-1:0]   win_wdata;
    logic [NREQ-1:0] id_onehot;
    logic [NREQ-1:0] ack_vec;
    logic            grant_err;
    logic            full;
    logic            empty;

    genvar gi;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
            assign id_onehot[gi] = (id_reg == IW'(gi));
        end
    endgenerate

    assign win_wdata = wdata_arr[win_idx];
    assign full      = (count_reg == AW'(DEPTH));
    assign empty     = (count_reg == '0);

    // An error response leaves IDLE straight for RESP, before id_reg is loaded.
    assign ack_vec = (state_reg == IDLE) ? win_grant : id_onehot;

    always_comb begin
        state_next = state_reg;
        grant_err  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush && win_any) begin
                    if (req_push[win_idx] ? full : empty) begin
                        state_next = RESP;
                        grant_err  = ERR;
                    end else if (req_push[win_idx]) begin
                        state_next = PUSH;
                    end else begin
                        state_next = POP_RD;
                    end
                end
            end
            PUSH:     state_next = RESP;
            POP_RD:   state_next = POP_WAIT;
            POP_WAIT: state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            rr_ptr_reg     <= '0;
            id_reg         <= '0;
            flush_pend_reg <= 1'b0;
            req_ack_reg    <= '0;
            req_err_reg    <= 1'b0;
            req_rdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && state_next != IDLE) begin
                id_reg <= win_idx;
            end

            case (state_reg)
                IDLE:    if (flush) count_reg <= '0;
                PUSH:    count_reg <= count_reg + 1'b1;
                POP_RD:  count_reg <= count_reg - 1'b1;
                RESP:    if (flush || flush_pend_reg) count_reg <= '0;
                default: ;
            endcase

            // A flush seen mid-transaction is held until the op has acked.
            if (state_reg == RESP) begin
                flush_pend_reg <= 1'b0;
            end else if (state_reg != IDLE && flush) begin
                flush_pend_reg <= 1'b1;
            end

            if (state_reg == RESP) begin
                rr_ptr_reg <= (id_reg == IW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
            end

            // Outputs are loaded from the next state so they line up with it.
            mem_we_reg    <= (state_next == PUSH);
            mem_re_reg    <= (state_next == POP_RD);
            mem_wdata_reg <= (state_next == PUSH) ? win_wdata : '0;
            if (state_next == PUSH) begin
                mem_addr_reg <= count_reg;
            end else if (state_next == POP_RD) begin
                mem_addr_reg <= count_reg - 1'b1;
            end else begin
                mem_addr_reg <= '0;
            end

            req_ack_reg   <= (state_next == RESP) ? ack_vec : '0;
            req_err_reg   <= (state_next == RESP) && grant_err;
            req_rdata_reg <= (state_next == RESP && state_reg == POP_WAIT) ? mem_rdata : '0;
        end
    end

    assign req_ack     = req_ack_reg;
    assign req_err     = req_err_reg;
    assign req_rdata   = req_rdata_reg;
    assign grant_id    = id_reg;
    assign mem_we      = mem_we_reg;
    assign mem_re      = mem_re_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign stack_count = count_reg;
    assign stack_full  = full;
    assign stack_empty = empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter: expected acks and RAM accesses are queued
// when a request is driven and compared when the DUT produces them.
module tb_stack_arbiter;

    localparam int NREQ  = 2;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic            err;
        logic [DW-1:0]   rdata;
    } tx_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_push;
    logic [NREQ*DW-1:0] req_wdata;
    logic               flush;
    logic [NREQ-1:0]    req_ack;
    logic               req_err;
    logic [DW-1:0]      req_rdata;
    logic [0:0]         grant_id;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_re;
    logic [DW-1:0]      mem_rdata;
    logic [AW-1:0]      stack_count;
    logic               stack_full;
    logic               stack_empty;

    int checks   = 0;
    int failures = 0;

    tx_t           exp_tx [$];
    wr_t           exp_wr [$];
    logic [AW-1:0] exp_rd [$];
    logic [DW-1:0] model  [$];

    logic [DW-1:0] ram [16];
    logic [DW-1:0] ram_q = '0;

    stack_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_push    (req_push),
        .req_wdata   (req_wdata),
        .flush       (flush),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .req_rdata   (req_rdata),
        .grant_id    (grant_id),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .stack_count (stack_count),
        .stack_full  (stack_full),
        .stack_empty (stack_empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_we) ram[mem_addr[3:0]] <= mem_wdata;
        if (mem_re) ram_q <= ram[mem_addr[3:0]];
    end
    assign mem_rdata = ram_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare every ack and RAM access against the queues.
    always @(negedge clock) begin
        if (reset_n) begin
            if (req_ack != '0) begin
                if (exp_tx.size() == 0) begin
                    check("unexpected_ack", req_ack, 0);
                end else begin
                    tx_t t;
                    t = exp_tx.pop_front();
                    check("ack_id", req_ack, t.ack);
                    check("ack_err", req_err, t.err);
                    check("ack_rdata", req_rdata, t.rdata);
                    $display("ack=%b err=%0d rdata=0x%08h count=%0d", req_ack, req_err, req_rdata, stack_count);
                end
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_mem_we", mem_we, 0);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                end
            end
            if (mem_re) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_mem_re", mem_re, 0);
                end else begin
                    check("rd_addr", mem_addr, exp_rd.pop_front());
                end
            end
        end
    end

    // Queue the expected outcome of one request from the bench's own stack model.
    task automatic expect_req(input int id, input bit push, input logic [DW-1:0] data, output bit err);
        tx_t t;
        wr_t w;
        t.ack   = NREQ'(1) << id;
        t.rdata = '0;
        if (push) begin
            err = (model.size() == DEPTH);
            if (!err) begin
                w.addr = AW'(model.size());
                w.data = data;
                exp_wr.push_back(w);
                model.push_back(data);
            end
        end else begin
            err = (model.size() == 0);
            if (!err) begin
                exp_rd.push_back(AW'(model.size() - 1));
                t.rdata = model.pop_back();
            end
        end
        t.err = err;
        exp_tx.push_back(t);
    endtask

    task automatic do_req(input int id, input bit push, input logic [DW-1:0] data, input bit flush_first);
        bit err;
        int lat;
        int exp_lat;
        @(negedge clock);
        if (flush_first) begin
            flush = 1'b1;
            model.delete();
        end
        expect_req(id, push, data, err);
        exp_lat = err ? 1 : (push ? 2 : 3);
        if (flush_first) exp_lat++;
        req_valid[id]            = 1'b1;
        req_push[id]             = push;
        req_wdata[id*DW +: DW]   = data;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            flush = 1'b0;
            lat++;
        end while (!req_ack[id] && lat < 20);
        check($sformatf("latency_r%0d_%s", id, push ? "push" : "pop"), lat, exp_lat);
        req_valid[id] = 1'b0;
        @(posedge clock);
    endtask

    initial begin
        int n;
        int cyc;
        bit err;
        reset_n   = 1'b0;
        req_valid = '0;
        req_push  = '0;
        req_wdata = '0;
        flush     = 1'b0;

        // Reset then idle
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("idle_ack_we", {req_ack, mem_we, mem_re}, 0);
        end
        check("reset_count", stack_count, 0);
        check("reset_empty", stack_empty, 1);
        check("reset_grant", grant_id, 0);

        // Push then pop through requester 0
        do_req(0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("count_after_push", stack_count, 1);
        do_req(0, 1'b0, 32'h0, 1'b0);
        check("count_after_pop", stack_count, 0);

        // Both requesters pushing continuously alternate from a fresh reset
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model.delete();
        expect_req(0, 1'b1, 32'h11, err);
        expect_req(1, 1'b1, 32'h22, err);
        expect_req(0, 1'b1, 32'h11, err);
        expect_req(1, 1'b1, 32'h22, err);
        req_push  = 2'b11;
        req_wdata = {32'h22, 32'h11};
        req_valid = 2'b11;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (req_ack != '0) begin
                n++;
                if (n == 4) req_valid = '0;
            end
        end
        check("alt_ack_total", n, 4);
        @(posedge clock);
        #1;
        check("alt_count", stack_count, 4);
        check("alt_full", stack_full, 1);

        // Overflow then underflow against DEPTH=4, starting with an IDLE flush
        do_req(0, 1'b1, 32'hA000_0000, 1'b1);
        for (int i = 1; i < 5; i++) do_req(0, 1'b1, 32'hA000_0000 + i, 1'b0);
        check("ovf_count", stack_count, 4);
        check("ovf_full", stack_full, 1);
        for (int i = 0; i < 5; i++) do_req(0, 1'b0, 32'h0, 1'b0);
        check("unf_count", stack_count, 0);
        check("unf_empty", stack_empty, 1);

        // Flush raised during POP_WAIT lets the pop finish first
        for (int i = 0; i < 3; i++) do_req(1, 1'b1, 32'hB000_0000 + i, 1'b0);
        @(negedge clock);
        expect_req(0, 1'b0, 32'h0, err);
        req_valid[0] = 1'b1;
        req_push[0]  = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_pop_ack", req_ack, 2'b01);
        check("flush_pop_count", stack_count, 2);
        req_valid[0] = 1'b0;
        @(posedge clock);
        #1;
        check("flush_applied_count", stack_count, 0);
        model.delete();

        // Reset dropped during POP_RD aborts without an ack
        do_req(0, 1'b1, 32'hC0, 1'b0);
        do_req(0, 1'b1, 32'hC1, 1'b0);
        @(negedge clock);
        expect_req(1, 1'b0, 32'h0, err);
        req_valid[1] = 1'b1;
        req_push[1]  = 1'b0;
        @(posedge clock);
        #1;
        check("poprd_mem_re", mem_re, 1);
        reset_n = 1'b0;
        #1;
        check("rst_outputs", {req_ack, req_err, mem_we, mem_re}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_count", stack_count, 0);
        check("rst_grant", grant_id, 0);
        req_valid = '0;
        exp_tx.delete();
        exp_rd.delete();
        model.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_empty", stack_empty, 1);
        do_req(1, 1'b1, 32'hD0, 1'b0);
        check("post_rst_count", stack_count, 1);

        repeat (3) @(posedge clock);
        check("tx_left", exp_tx.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("rd_left", exp_rd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
